mdu_iter: RTL and testbench



---
 rtl/mdu_iter.sv | 177 +++++++++++++++++
 tb/tb_mdu_iter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RISC-V M-extension multiply/divide unit
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle
// beside the single-cycle ALU in the execute stage.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   InValid   operation request            InReady   unit idle, can accept
//   Funct3    operation select             SrcA/SrcB rs1 / rs2 operands
//   Flush     synchronous abort of any in-flight operation
//   OutValid  Result valid                 OutReady  consumer takes Result
//   Result    registered result            Busy      operation in flight
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q,   state_d;
  logic [2:0]        funct_q,   funct_d;
  logic              neg_q,     neg_d;      // product / quotient negation
  logic              neg_rem_q, neg_rem_d;  // remainder negation (dividend sign)
  logic              spec_q,    spec_d;     // Result already holds a special-case value
  logic [XLEN-1:0]   opnd_q,    opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q,     acc_d;      // {high/remainder, low/multiplier/quotient}
  logic [CW-1:0]     count_q,   count_d;
  logic [XLEN-1:0]   result_q,  result_d;

  // Acceptance-time decode
  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;

  // One iteration step and final fix-up
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

  always_comb begin
    is_div   = Funct3[2];
    a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
               (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    sign_a   = a_signed && SrcA[XLEN-1];
    sign_b   = b_signed && SrcB[XLEN-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = is_div && (SrcB == '0);
    div_ovf  = is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    if (div_zero) spec_val = Funct3[1] ? SrcA : '1;
    else          spec_val = Funct3[1] ? '0 : SrcA;
  end

  always_comb begin
    // Shift-add: add multiplicand to the high half when the current
    // multiplier bit (LSB) is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Restoring division: the shifted partial remainder needs XLEN+1 bits;
    // a borrow out of the trial subtraction means restore.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_next  = {(div_trial[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~div_trial[XLEN]};
    step_next = funct_q[2] ? div_next : mul_next;

    prod_fix = neg_q     ? -step_next : step_next;
    quot_fix = neg_q     ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    rem_fix  = neg_rem_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    case (funct_q)
      3'b000:                 final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quot_fix;
      default:                final_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    funct_d   = funct_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    spec_d    = spec_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result_d  = result_q;

    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            funct_d   = Funct3;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            opnd_d    = is_div ? mag_b : mag_a;
            acc_d     = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            state_d   = S_CALC;
            if (div_zero || div_ovf) begin
              // Result is decided now; a single pass through CALC gives
              // these ops a one-cycle latency from the acceptance edge.
              result_d = spec_val;
              spec_d   = 1'b1;
              count_d  = CW'(1);
            end else begin
              spec_d  = 1'b0;
              count_d = CW'(XLEN);
            end
          end
        end
        S_CALC: begin
          acc_d   = step_next;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            if (!spec_q) result_d = final_val;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      funct_q   <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      spec_q    <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      funct_q   <= funct_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      spec_q    <= spec_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      result_q  <= result_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign Busy     = (state_q != S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Result   = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter (XLEN=32)
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid, InReady, Flush, OutValid, OutReady, Busy;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB, Result;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the architectural definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};  sb = {{32{b[31]}}, b};
    ua = {32'b0, a};        ub = {32'b0, b};
    ia = a;                 ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 32;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue an op (unit must be idle), measure edges from acceptance to OutValid.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    chk("inready_before_op", {31'b0, InReady}, 32'd1);
    InValid = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    InValid = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 0;
    while (!OutValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    chk("inready_after_handoff", {31'b0, InReady}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(f, a, b, lat);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, Result, exp);
    handshake();
  endtask

  initial begin
    int lat;
    logic [31:0] held, last_res, ra, rb;
    logic [2:0]  rf;
    logic        seen_valid;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
    vecs[1]  = '{3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 32};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
    vecs[4]  = '{3'd5, 32'd100,        32'd7,         32'd14,        32};
    vecs[5]  = '{3'd7, 32'd100,        32'd7,         32'd2,         32};
    vecs[6]  = '{3'd4, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 32};
    vecs[7]  = '{3'd6, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    vecs[12] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 32};
    vecs[13] = '{3'd6, 32'd100,        32'hFFFF_FFF9, 32'd2,         32};

    rst_n = 1'b0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    Funct3 = 3'd0; SrcA = '0; SrcB = '0;
    #2;
    chk("reset_result",   Result, 32'h0);
    chk("reset_outvalid", {31'b0, OutValid}, 32'd0);
    chk("reset_inready",  {31'b0, InReady}, 32'd1);
    chk("reset_busy",     {31'b0, Busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom); ra = rand_opnd(); rb = rand_opnd();
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, rf, ra, rb), rf, ra, rb,
             ref_result(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    // Backpressure: Result and OutValid hold, InReady stays low.
    start_op(3'd5, 32'd1000, 32'd3, lat);
    chk("bp_latency", lat, 32);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_outvalid", {31'b0, OutValid}, 32'd1);
      chk("bp_result",   Result, 32'd333);
      chk("bp_inready",  {31'b0, InReady}, 32'd0);
    end
    handshake();
    run_op("bp_next", 3'd0, 32'd12, 32'd11, 32'd132, 32);
    last_res = 32'd132;

    // Flush at CALC cycle 10, with a competing InValid that must be ignored.
    start_op(3'd0, 32'd9, 32'd9, lat);  // load a known Result (81) before the flush
    handshake();
    last_res = 32'd81;
    chk("pre_flush_result", Result, last_res);
    InValid = 1'b1; Funct3 = 3'd3; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
    @(posedge clk); #1;
    InValid = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    Flush = 1'b1; InValid = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    chk("flush_inready",  {31'b0, InReady}, 32'd1);
    chk("flush_busy",     {31'b0, Busy}, 32'd0);
    chk("flush_outvalid", {31'b0, OutValid}, 32'd0);
    chk("flush_result_kept", Result, last_res);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (OutValid) seen_valid = 1'b1;
    end
    chk("flush_no_outvalid", {31'b0, seen_valid}, 32'd0);
    chk("flush_idle_after", {31'b0, InReady}, 32'd1);
    run_op("post_flush", 3'd7, 32'd50, 32'd8, 32'd2, 32);

    // Asynchronous reset mid-CALC.
    InValid = 1'b1; Funct3 = 3'd4; SrcA = 32'd77; SrcB = 32'd5;
    @(posedge clk); #1;
    InValid = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_result",   Result, 32'h0);
    chk("rst_mid_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_mid_inready",  {31'b0, InReady}, 32'd1);
    chk("rst_mid_busy",     {31'b0, Busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset", 3'd4, 32'd77, 32'd5, 32'd15, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
